// File: rtl/y86_run_ctrl.sv
// y86_run_ctrl
// Run/step controller for the Y86 core. Starts, steps and stops execution
// on harness command and gates the core through run_o. At each commit it
// looks at the instruction status (AOK/HLT/ADR/INS) and latches the status
// that ends the run. It also keeps saturating counters of enabled cycles and
// retired instructions.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      synchronous active-low reset
//   start_i      run continuously (IDLE/PAUSE)
//   step_i       execute one instruction (IDLE/PAUSE)
//   stop_i       pause at the next commit (RUN)
//   clear_i      leave HALTED/FAULT back to IDLE
//   commit_i     core retires an instruction this cycle
//   stat_i       status of committing instruction (00 AOK,01 HLT,10 ADR,11 INS)
//   run_o        core enable, high in RUN and STEP
//   state_o      state encoding IDLE=0 RUN=1 STEP=2 PAUSE=3 HALTED=4 FAULT=5
//   stat_o       latched terminating status
//   done_o       one-cycle pulse on entry to HALTED/FAULT
//   cycle_cnt_o  cycles with run_o high (saturating)
//   instr_cnt_o  retired instructions, AOK/HLT only (saturating)
module y86_run_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic             commit_i,
  input  logic [1:0]       stat_i,
  output logic             run_o,
  output logic [2:0]       state_o,
  output logic [1:0]       stat_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_HALTED = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             stop_pend_q, stop_pend_d;
  logic [1:0]       stat_q, stat_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;

  logic running;
  logic commit_v;
  logic clr_cnt;
  logic retire;

  assign running  = (state_q == ST_RUN) || (state_q == ST_STEP);
  // Commits outside RUN/STEP are protocol errors and are dropped here.
  assign commit_v = commit_i && running;
  assign retire   = commit_v && ((stat_i == STAT_AOK) || (stat_i == STAT_HLT));

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    stat_d      = stat_q;
    done_d      = 1'b0;
    clr_cnt     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i || step_i) begin
          state_d     = start_i ? ST_RUN : ST_STEP;
          clr_cnt     = 1'b1;
          stat_d      = STAT_AOK;
          stop_pend_d = 1'b0;
        end
      end
      ST_RUN, ST_STEP: begin
        if (commit_v) begin
          if (stat_i == STAT_HLT) begin
            state_d = ST_HALTED;
            stat_d  = stat_i;
            done_d  = 1'b1;
          end else if (stat_i != STAT_AOK) begin
            state_d = ST_FAULT;
            stat_d  = stat_i;
            done_d  = 1'b1;
          end else if (state_q == ST_STEP || stop_i || stop_pend_q) begin
            state_d = ST_PAUSE;
          end
        end else if (state_q == ST_RUN && stop_i) begin
          stop_pend_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (start_i) begin
          state_d = ST_RUN;
        end else if (step_i) begin
          state_d = ST_STEP;
        end
      end
      ST_HALTED, ST_FAULT: begin
        if (clear_i) begin
          state_d = ST_IDLE;
          clr_cnt = 1'b1;
          stat_d  = STAT_AOK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A pending stop never survives leaving RUN (includes a same-cycle
    // terminating commit, where termination wins).
    if (state_d != ST_RUN) begin
      stop_pend_d = 1'b0;
    end

    cyc_d = cyc_q;
    ins_d = ins_q;
    if (clr_cnt) begin
      cyc_d = '0;
      ins_d = '0;
    end else begin
      if (running && cyc_q != CNT_MAX) begin
        cyc_d = cyc_q + CNT_ONE;
      end
      if (retire && ins_q != CNT_MAX) begin
        ins_d = ins_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      stop_pend_q <= 1'b0;
      stat_q      <= STAT_AOK;
      done_q      <= 1'b0;
      cyc_q       <= '0;
      ins_q       <= '0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      stat_q      <= stat_d;
      done_q      <= done_d;
      cyc_q       <= cyc_d;
      ins_q       <= ins_d;
    end
  end

  assign run_o       = running;
  assign state_o     = state_q;
  assign stat_o      = stat_q;
  assign done_o      = done_q;
  assign cycle_cnt_o = cyc_q;
  assign instr_cnt_o = ins_q;

endmodule
